// File: rtl/imm_extend_pipe_pkg.sv
// Shared constants for the MERC-16 immediate path: size encodings and default widths.
package imm_extend_pipe_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 16;
    localparam int unsigned FIELD_WIDTH_DEF = 11;

    typedef enum logic [1:0] {
        SZ_W0     = 2'd0,
        SZ_W1     = 2'd1,
        SZ_W2     = 2'd2,
        SZ_W2_ALT = 2'd3
    } size_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: sign/zero extension from a runtime width,
// or merge of a latched prefix above the low field bits.
module imm_extend_core #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FIELD_WIDTH = 11,
    parameter int unsigned WB          = 5
) (
    input  logic [FIELD_WIDTH-1:0] field,
    input  logic [WB-1:0]          width,
    input  logic                   is_signed,
    input  logic [DATA_WIDTH-1:0]  prefix,
    input  logic                   use_prefix,
    output logic [DATA_WIDTH-1:0]  ext
);

    logic [DATA_WIDTH-1:0] low;
    logic [DATA_WIDTH-1:0] mask;
    logic                  sign;

    always_comb begin
        low  = '0;
        mask = '0;
        sign = 1'b0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (i < int'(width)) begin
                mask[i] = 1'b1;
            end
        end
        for (int i = 0; i < int'(FIELD_WIDTH); i++) begin
            if (i < int'(width)) begin
                low[i] = field[i];
            end
            if (i == int'(width) - 1) begin
                sign = field[i];
            end
        end
        // Prefix bits shifted past DATA_WIDTH are dropped silently.
        if (use_prefix) begin
            ext = (prefix << width) | low;
        end else if (is_signed && sign) begin
            ext = low | ~mask;
        end else begin
            ext = low;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered, handshaked immediate generator for the MERC-16 decode stage.
// Prefix merging is built only when IMM_PREFIX_EN is defined.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned FIELD_WIDTH = FIELD_WIDTH_DEF,
    parameter int unsigned W0          = 4,
    parameter int unsigned W1          = 8,
    parameter int unsigned W2          = 11
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [FIELD_WIDTH-1:0] Field,
    input  logic [1:0]             Size,
    input  logic                   Signed,
    input  logic                   IsPrefix,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [DATA_WIDTH-1:0]  Out,
    output logic                   PrefixPending,
    output logic                   PrefixOverrun
);

    localparam int unsigned WB = $clog2(DATA_WIDTH + 1);

    logic                  accept;
    logic                  take_prefix;
    logic [WB-1:0]         w_sel;
    logic [DATA_WIDTH-1:0] merge_prefix;
    logic                  merge_use;
    logic [DATA_WIDTH-1:0] core_out;

    assign InReady = !OutValid || OutReady;
    assign accept  = InValid && InReady;

    always_comb begin
        w_sel = WB'(W2);
        case (size_e'(Size))
            SZ_W0:   w_sel = WB'(W0);
            SZ_W1:   w_sel = WB'(W1);
            default: w_sel = WB'(W2);
        endcase
    end

`ifdef IMM_PREFIX_EN
    logic [DATA_WIDTH-1:0] prefix_q;
    logic                  pending_q;
    logic                  overrun_q;
    logic [DATA_WIDTH-1:0] prefix_ext;

    assign take_prefix  = accept && IsPrefix;
    assign prefix_ext   = {{(DATA_WIDTH - FIELD_WIDTH){Signed & Field[FIELD_WIDTH-1]}}, Field};
    assign merge_prefix = prefix_q;
    assign merge_use    = pending_q;

    // Prefix state: latched by a prefix beat, consumed by the next normal beat.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prefix_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (Flush) begin
            prefix_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= take_prefix && pending_q;
            if (take_prefix) begin
                prefix_q  <= prefix_ext;
                pending_q <= 1'b1;
            end else if (accept) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign PrefixPending = pending_q;
    assign PrefixOverrun = overrun_q;
`else
    logic unused_is_prefix;

    assign unused_is_prefix = IsPrefix;
    assign take_prefix      = 1'b0;
    assign merge_prefix     = '0;
    assign merge_use        = 1'b0;
    assign PrefixPending    = 1'b0;
    assign PrefixOverrun    = 1'b0;
`endif

    imm_extend_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FIELD_WIDTH (FIELD_WIDTH),
        .WB          (WB)
    ) u_core (
        .field      (Field),
        .width      (w_sel),
        .is_signed  (Signed),
        .prefix     (merge_prefix),
        .use_prefix (merge_use),
        .ext        (core_out)
    );

    // Output register: loads on a normal beat, drains when the consumer takes it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            OutValid <= 1'b0;
            Out      <= '0;
        end else if (Flush) begin
            OutValid <= 1'b0;
            Out      <= '0;
        end else if (accept && !take_prefix) begin
            OutValid <= 1'b1;
            Out      <= core_out;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe; prefix steps follow IMM_PREFIX_EN.
module tb_imm_extend_pipe;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [10:0] Field;
    logic [1:0]  Size;
    logic        Signed;
    logic        IsPrefix;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] Out;
    logic        PrefixPending;
    logic        PrefixOverrun;

    int total = 0;
    int bad   = 0;

    imm_extend_pipe dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Flush         (Flush),
        .InValid       (InValid),
        .InReady       (InReady),
        .Field         (Field),
        .Size          (Size),
        .Signed        (Signed),
        .IsPrefix      (IsPrefix),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .Out           (Out),
        .PrefixPending (PrefixPending),
        .PrefixOverrun (PrefixOverrun)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [10:0] f, input logic [1:0] sz, input logic sg, input logic pf);
        InValid  = 1'b1;
        Field    = f;
        Size     = sz;
        Signed   = sg;
        IsPrefix = pf;
    endtask

    // Present one beat for a single cycle, then idle the input.
    task automatic beat(input logic [10:0] f, input logic [1:0] sz, input logic sg, input logic pf);
        drive(f, sz, sg, pf);
        tick();
        InValid  = 1'b0;
        IsPrefix = 1'b0;
    endtask

    function automatic int width_of(input int sz);
        return (sz == 0) ? 4 : (sz == 1) ? 8 : 11;
    endfunction

    function automatic logic [15:0] ref_ext(input logic [10:0] f, input int w, input bit s);
        logic [31:0] v;
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        v = {21'd0, f} & m;
        if (s && v[w-1]) v = v | ~m;
        return v[15:0];
    endfunction

    logic [10:0] f;
    logic [15:0] held;
    int          w;

    initial begin
        Reset    = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        Field    = '0;
        Size     = '0;
        Signed   = 1'b0;
        IsPrefix = 1'b0;
        OutReady = 1'b1;
        #2;
        chk1 ("rst_outvalid", OutValid, 1'b0);
        chk16("rst_out", Out, 16'h0000);
        chk1 ("rst_pending", PrefixPending, 1'b0);
        chk1 ("rst_overrun", PrefixOverrun, 1'b0);
        chk1 ("rst_inready", InReady, 1'b1);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        beat(11'h008, 2'd0, 1'b1, 1'b0);
        chk16("ex_signed", Out, 16'hFFF8);
        chk1 ("ex_valid", OutValid, 1'b1);
        beat(11'h008, 2'd0, 1'b0, 1'b0);
        chk16("ex_unsigned", Out, 16'h0008);
        beat(11'h7F8, 2'd0, 1'b0, 1'b0);
        chk16("upper_ignored", Out, 16'h0008);
        beat(11'h400, 2'd3, 1'b1, 1'b0);
        chk16("size3_signed", Out, 16'hFC00);
        beat(11'h400, 2'd2, 1'b0, 1'b0);
        chk16("size2_unsigned", Out, 16'h0400);

        // Back-to-back sweep over every field value, with noise above the width.
        for (int sg = 0; sg < 2; sg++) begin
            for (int sz = 0; sz < 3; sz++) begin
                w = width_of(sz);
                for (int v = 0; v < (1 << w); v++) begin
                    f = 11'(v) | 11'($urandom << w);
                    drive(f, 2'(sz), 1'(sg), 1'b0);
                    tick();
                    chk16("sweep_out", Out, ref_ext(f, w, 1'(sg)));
                    chk1 ("sweep_valid", OutValid, 1'b1);
                end
            end
        end
        InValid = 1'b0;
        tick();
        chk1("drain_idle", OutValid, 1'b0);

        // Backpressure: hold for three cycles, then accept on release.
        OutReady = 1'b0;
        beat(11'h005, 2'd0, 1'b0, 1'b0);
        held = Out;
        chk16("bp_first", held, 16'h0005);
        drive(11'h080, 2'd1, 1'b1, 1'b0);
        #1;
        chk1("bp_inready_low", InReady, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk16("bp_hold_out", Out, 16'h0005);
            chk1 ("bp_hold_valid", OutValid, 1'b1);
            chk1 ("bp_hold_inready", InReady, 1'b0);
        end
        OutReady = 1'b1;
        #1;
        chk1("bp_release_inready", InReady, 1'b1);
        tick();
        InValid = 1'b0;
        chk16("bp_next_out", Out, 16'hFF80);
        chk1 ("bp_next_valid", OutValid, 1'b1);
        tick();

`ifdef IMM_PREFIX_EN
        beat(11'h012, 2'd0, 1'b0, 1'b1);
        chk1("pfx_pending_set", PrefixPending, 1'b1);
        chk1("pfx_no_output", OutValid, 1'b0);
        beat(11'h00A, 2'd0, 1'b1, 1'b0);
        chk16("pfx_merge", Out, 16'h012A);
        chk1 ("pfx_pending_clr", PrefixPending, 1'b0);

        beat(11'h001, 2'd0, 1'b1, 1'b1);
        chk1("ovr_first", PrefixOverrun, 1'b0);
        chk1("ovr_drain", OutValid, 1'b0);
        beat(11'h7FF, 2'd0, 1'b1, 1'b1);
        chk1("ovr_pulse", PrefixOverrun, 1'b1);
        beat(11'h005, 2'd1, 1'b0, 1'b0);
        chk1 ("ovr_pulse_end", PrefixOverrun, 1'b0);
        chk16("ovr_merge", Out, 16'hFF05);
        chk1 ("ovr_pending_clr", PrefixPending, 1'b0);
`else
        beat(11'h7FF, 2'd2, 1'b1, 1'b1);
        chk16("noprefix_out", Out, 16'hFFFF);
        chk1 ("noprefix_valid", OutValid, 1'b1);
        chk1 ("noprefix_pending", PrefixPending, 1'b0);
        chk1 ("noprefix_overrun", PrefixOverrun, 1'b0);
`endif

        // Flush discards the presented beat and any prefix.
        beat(11'h006, 2'd0, 1'b0, 1'b0);
        chk1("fl_pre_valid", OutValid, 1'b1);
`ifdef IMM_PREFIX_EN
        beat(11'h0FF, 2'd0, 1'b0, 1'b1);
        chk1("fl_pre_pending", PrefixPending, 1'b1);
`endif
        Flush = 1'b1;
        drive(11'h001, 2'd0, 1'b0, 1'b0);
        tick();
        Flush   = 1'b0;
        InValid = 1'b0;
        chk1("fl_valid", OutValid, 1'b0);
        chk1("fl_pending", PrefixPending, 1'b0);
        beat(11'h003, 2'd0, 1'b1, 1'b0);
        chk16("fl_next", Out, 16'h0003);

        // Asynchronous reset between edges clears outputs at once.
        OutReady = 1'b0;
        tick();
        chk1("ar_pre_valid", OutValid, 1'b1);
        @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        chk1 ("ar_valid", OutValid, 1'b0);
        chk16("ar_out", Out, 16'h0000);
        chk1 ("ar_pending", PrefixPending, 1'b0);
        tick();
        Reset    = 1'b1;
        OutReady = 1'b1;
        tick();
        chk1("ar_stays_idle", OutValid, 1'b0);
        beat(11'h0C0, 2'd1, 1'b1, 1'b0);
        chk16("ar_first_beat", Out, 16'hFFC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
